// File: rtl/decode_operand_stage.sv
// RV32I decode / operand-fetch stage: register-file read with writeback bypass,
// one registered packet per instruction to execute, with stall and flush.
module decode_operand_stage #(
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [REGISTER_WIDTH-1:0] in_pc,
    output logic [4:0]                rs1_addr,
    output logic [4:0]                rs2_addr,
    input  logic [REGISTER_WIDTH-1:0] rs1_data,
    input  logic [REGISTER_WIDTH-1:0] rs2_data,
    input  logic                      wb_en,
    input  logic [4:0]                wb_rd,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_funct3,
    output logic [6:0]                out_funct7,
    output logic [4:0]                out_rd,
    output logic [REGISTER_WIDTH-1:0] out_input1,
    output logic [REGISTER_WIDTH-1:0] out_input2,
    output logic [REGISTER_WIDTH-1:0] out_pc,
    output logic                      out_illegal
);
    localparam int W = REGISTER_WIDTH;

    typedef struct packed {
        logic [6:0]   opcode;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
        logic [4:0]   rd;
        logic [W-1:0] input1;
        logic [W-1:0] input2;
        logic [W-1:0] pc;
        logic         illegal;
    } pkt_t;

    pkt_t         pkt_d, pkt_q;
    logic         valid_q;
    logic         accept;
    logic [W-1:0] src1, src2;
    logic [W-1:0] imm_i, imm_u;
    logic         legal;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // x0 reads zero even if writeback targets it
    always_comb begin
        src1 = rs1_data;
        if (rs1_addr == 5'd0)                   src1 = '0;
        else if (wb_en && (wb_rd == rs1_addr))  src1 = wb_data;
        src2 = rs2_data;
        if (rs2_addr == 5'd0)                   src2 = '0;
        else if (wb_en && (wb_rd == rs2_addr))  src2 = wb_data;
    end

    assign imm_i = W'($signed(in_instr[31:20]));
    assign imm_u = W'($signed({in_instr[31:12], 12'b0}));

    always_comb begin
        pkt_d        = '0;
        pkt_d.opcode = in_instr[6:0];
        pkt_d.funct3 = in_instr[14:12];
        pkt_d.funct7 = in_instr[31:25];
        pkt_d.rd     = in_instr[11:7];
        pkt_d.pc     = in_pc;
        legal        = 1'b0;
        case (pkt_d.opcode)
            7'b0110011: begin
                legal = (pkt_d.funct7 == 7'b0000000) ||
                        ((pkt_d.funct7 == 7'b0100000) &&
                         ((pkt_d.funct3 == 3'b000) || (pkt_d.funct3 == 3'b101)));
                pkt_d.input1 = src1;
                pkt_d.input2 = src2;
            end
            7'b0010011: begin
                case (pkt_d.funct3)
                    3'b001:  legal = (pkt_d.funct7 == 7'b0000000);
                    3'b101:  legal = (pkt_d.funct7 == 7'b0000000) ||
                                     (pkt_d.funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                pkt_d.input1 = src1;
                pkt_d.input2 = imm_i;
            end
            7'b0110111: begin
                legal        = 1'b1;
                pkt_d.input2 = imm_u;
            end
            7'b0010111: begin
                legal        = 1'b1;
                pkt_d.input1 = in_pc;
                pkt_d.input2 = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            pkt_d.input1 = '0;
            pkt_d.input2 = '0;
        end
        pkt_d.illegal = !legal;
    end

    // Data regs load only on accept so a stalled or drained packet stays bit-stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pkt_q   <= pkt_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = pkt_q.opcode;
    assign out_funct3  = pkt_q.funct3;
    assign out_funct7  = pkt_q.funct7;
    assign out_rd      = pkt_q.rd;
    assign out_input1  = pkt_q.input1;
    assign out_input2  = pkt_q.input2;
    assign out_pc      = pkt_q.pc;
    assign out_illegal = pkt_q.illegal;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage with hand-computed expectations.
module tb_decode_operand_stage;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [31:0] out_input1, out_input2, out_pc;
    logic        out_illegal;

    int checks = 0;
    int failures = 0;

    decode_operand_stage #(.REGISTER_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_input1(out_input1), .out_input2(out_input2),
        .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one instruction at the falling edge, let the rising edge take it, sample 1ns later
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        @(negedge clk);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        rs1_data = d1; rs2_data = d2; wb_en = we; wb_rd = wrd; wb_data = wd;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; wb_en = 1'b0;
    endtask

    task automatic chk_pkt(input string tag, input logic [31:0] in1, input logic [31:0] in2,
                           input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".in1"}, out_input1, in1);
        chk({tag, ".in2"}, out_input2, in2);
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        out_ready = 1'b1;
        #2;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.in2", out_input2, 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd1);
        @(negedge clk); reset = 1'b0;

        // ADDI x5,x0,-1
        send(32'hFFF00293, 32'h0, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0);
        chk_pkt("addi", 32'h0, 32'hFFFFFFFF, 5'd5, 1'b0);
        chk("addi.op", 32'(out_opcode), 32'h13);
        chk("addi.f3", 32'(out_funct3), 32'h0);

        // ADD x1,x3,x4 with rs1 bypass; address decode is combinational
        @(negedge clk); in_instr = 32'h004180B3; #1;
        chk("add.rs1a", 32'(rs1_addr), 32'd3);
        chk("add.rs2a", 32'(rs2_addr), 32'd4);
        send(32'h004180B3, 32'h0, 32'd7, 32'd9, 1'b1, 5'd3, 32'h1234);
        chk_pkt("add.byp1", 32'h1234, 32'd9, 5'd1, 1'b0);
        // rs2-only bypass
        send(32'h004180B3, 32'h0, 32'd7, 32'd9, 1'b1, 5'd4, 32'hABCD);
        chk_pkt("add.byp2", 32'd7, 32'hABCD, 5'd1, 1'b0);
        // ADD x1,x0,x4 with wb_rd=0: x0 stays zero
        send(32'h004000B3, 32'h0, 32'd7, 32'd9, 1'b1, 5'd0, 32'h1234);
        chk_pkt("add.x0", 32'h0, 32'd9, 5'd1, 1'b0);

        // LUI / AUIPC
        send(32'h12345137, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("lui", 32'h0, 32'h12345000, 5'd2, 1'b0);
        send(32'h00001097, 32'h100, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("auipc", 32'h100, 32'h1000, 5'd1, 1'b0);
        chk("auipc.pc", out_pc, 32'h100);

        // Illegal and funct7 legality boundaries (rs data nonzero to prove forcing)
        send(32'h00000000, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("ill.zero", 32'h0, 32'h0, 5'd0, 1'b1);
        send(32'h40209033, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("ill.sll7", 32'h0, 32'h0, 5'd0, 1'b1);
        chk("ill.f7", 32'(out_funct7), 32'h20);
        send(32'h40208033, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("sub", 32'd7, 32'd9, 5'd0, 1'b0);
        send(32'h4030D293, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("srai", 32'd7, 32'h403, 5'd5, 1'b0);
        send(32'h40109293, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("ill.slli", 32'h0, 32'h0, 5'd5, 1'b1);
        send(32'h02208033, 32'h0, 32'd7, 32'd9, 1'b0, 5'd0, 32'h0);
        chk_pkt("ill.mul", 32'h0, 32'h0, 5'd0, 1'b1);

        // Back-to-back with 3-cycle stall after the first packet
        send(32'h00100313, 32'h10, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0);
        chk_pkt("b2b.a", 32'h0, 32'd1, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_instr = 32'h00200393; in_pc = 32'h14; out_ready = 1'b0;
            #1 chk("b2b.stall.rdy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk_pkt("b2b.held", 32'h0, 32'd1, 5'd6, 1'b0);
            chk("b2b.held.pc", out_pc, 32'h10);
        end
        @(negedge clk); out_ready = 1'b1;
        #1 chk("b2b.rel.rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk_pkt("b2b.b", 32'h0, 32'd2, 5'd7, 1'b0);
        send(32'h00300413, 32'h18, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0);
        chk_pkt("b2b.c", 32'h0, 32'd3, 5'd8, 1'b0);
        @(negedge clk); @(posedge clk); #1;
        chk("b2b.drain", 32'(out_valid), 32'd0);
        chk("b2b.drain.rd", 32'(out_rd), 32'd8);

        // Flush while stalled with a pending offer
        send(32'h00100313, 32'h20, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00200393; out_ready = 1'b0; flush = 1'b1;
        #1 chk("flush.rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("flush.valid", 32'(out_valid), 32'd0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush.after", 32'(out_valid), 32'd0);
        chk("flush.rd", 32'(out_rd), 32'd6);

        // Asynchronous reset mid-stream
        send(32'h12345137, 32'h0, 32'd0, 32'd0, 1'b0, 5'd0, 32'h0);
        chk("arst.pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.in2", out_input2, 32'd0);
        chk("arst.rd", 32'(out_rd), 32'd0);
        chk("arst.op", 32'(out_opcode), 32'd0);
        @(negedge clk); reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
